// File: rtl/top_downsample.sv
// 2x2 average-pool downsampler: captures a (2N)x(2N) matrix on start, then
// writes one rounded block average per clock into the registered output matrix.
module top_downsample #(
  parameter int number_of_row = 4,
  parameter int length        = 12,
  parameter int frac          = 8
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic [length*4*number_of_row*number_of_row-1:0] din,
  output logic [length*number_of_row*number_of_row-1:0]   dout,
  output logic                                           busy,
  output logic                                           done
);

  localparam int N  = number_of_row;
  localparam int L  = length;
  localparam int W2 = 2 * N;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Averaging keeps the fixed-point format, so frac only has to fit the word.
  if (frac > length) begin : g_bad_frac
    $error("top_downsample: frac must not exceed length");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              r_state;
  logic [L*4*N*N-1:0]  r_din;
  logic [IW-1:0]       r_row;
  logic [IW-1:0]       r_col;

  logic [L-1:0]        w_a;
  logic [L-1:0]        w_b;
  logic [L-1:0]        w_c;
  logic [L-1:0]        w_d;
  logic [L+1:0]        w_sum;
  logic [L-1:0]        w_avg;
  int                  w_top;
  int                  w_oidx;

  always_comb begin
    w_top  = (2 * int'(r_row) * W2 + 2 * int'(r_col)) * L;
    w_oidx = (int'(r_row) * N + int'(r_col)) * L;
    w_a    = r_din[w_top +: L];
    w_b    = r_din[w_top + L +: L];
    w_c    = r_din[w_top + W2 * L +: L];
    w_d    = r_din[w_top + (W2 + 1) * L +: L];
    // Four L-bit terms plus the rounding constant fit in L+2 bits.
    w_sum  = {2'b00, w_a} + {2'b00, w_b} + {2'b00, w_c} + {2'b00, w_d} + (L+2)'(2);
    w_avg  = w_sum[L+1:2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_din   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      dout    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_din   <= din;
            dout    <= '0;
            done    <= 1'b0;
            busy    <= 1'b1;
            r_row   <= '0;
            r_col   <= '0;
            r_state <= CALC;
          end
        end
        CALC: begin
          dout[w_oidx +: L] <= w_avg;
          if (r_col == IW'(N - 1)) begin
            r_col <= '0;
            if (r_row == IW'(N - 1)) begin
              r_row   <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= DONE;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_top_downsample.sv
// Scoreboard bench for top_downsample: stimulus queues the expected matrix,
// a negedge monitor pops and compares it on every rising edge of done.
module tb_top_downsample;

  localparam int N  = 4;
  localparam int L  = 12;
  localparam int DI = L * 4 * N * N;
  localparam int DO = L * N * N;

  typedef logic [DI-1:0] din_t;
  typedef logic [DO-1:0] dout_t;

  logic  clk;
  logic  rst;
  logic  start;
  din_t  din;
  dout_t dout;
  logic  busy;
  logic  done;

  top_downsample #(.number_of_row(N), .length(L), .frac(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .din  (din),
    .dout (dout),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    acc_cyc  = 0;
  int    bcnt     = 0;
  logic  prev_done = 1'b0;
  dout_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic dout_t model(input din_t v);
    dout_t r;
    int a, b, c, d;
    r = '0;
    for (int rr = 0; rr < N; rr++) begin
      for (int cc = 0; cc < N; cc++) begin
        a = int'(v[((2*rr)*2*N + 2*cc) * L +: L]);
        b = int'(v[((2*rr)*2*N + 2*cc + 1) * L +: L]);
        c = int'(v[((2*rr+1)*2*N + 2*cc) * L +: L]);
        d = int'(v[((2*rr+1)*2*N + 2*cc + 1) * L +: L]);
        r[(rr*N + cc) * L +: L] = L'((a + b + c + d + 2) / 4);
      end
    end
    return r;
  endfunction

  function automatic din_t set_el(input din_t v, input int r, input int c, input int x);
    din_t t;
    t = v;
    t[(r*2*N + c) * L +: L] = L'(x);
    return t;
  endfunction

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_v(input string name, input dout_t act, input dout_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int el(input int r, input int c);
    return int'(dout[(r*N + c) * L +: L]);
  endfunction

  // Monitor: done/busy exclusion every cycle, scoreboard pop on done rising.
  always @(negedge clk) begin
    if (busy) bcnt++;
    if (!rst) begin
      checks++;
      if (done && busy) begin
        failures++;
        $display("FAIL done_busy_exclusive actual=both_high expected=not_both");
      end
    end
    if (done && !prev_done) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done actual=done_rise expected=no_pending_run");
      end else begin
        dout_t e;
        e = q.pop_front();
        if (dout !== e) begin
          failures++;
          $display("FAIL scoreboard_dout actual=%0h expected=%0h", dout, e);
        end
      end
    end
    prev_done = done;
  end

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic issue(input din_t v, input bit hold);
    din   = v;
    start = 1'b1;
    q.push_back(model(v));
    bcnt  = 0;
    @(negedge clk);
    acc_cyc = cyc;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout actual=no_done expected=done_within_60", name);
    end
    chk_i({name, "_latency"}, cyc - acc_cyc, 16);
  endtask

  din_t v_ramp, v_rnd, v_b;

  initial begin
    v_ramp = '0;
    v_b    = '0;
    for (int i = 0; i < 4*N*N; i++) begin
      v_ramp[i*L +: L] = L'(35 + 10*i);
      v_b[i*L +: L]    = L'((i*397 + 11) % 4096);
    end
    v_rnd = '0;
    v_rnd = set_el(v_rnd, 0, 0, 1);    v_rnd = set_el(v_rnd, 0, 1, 1);
    v_rnd = set_el(v_rnd, 1, 0, 1);    v_rnd = set_el(v_rnd, 1, 1, 2);
    v_rnd = set_el(v_rnd, 0, 2, 1);    v_rnd = set_el(v_rnd, 0, 3, 1);
    v_rnd = set_el(v_rnd, 1, 2, 2);    v_rnd = set_el(v_rnd, 1, 3, 2);
    v_rnd = set_el(v_rnd, 1, 5, 3);
    v_rnd = set_el(v_rnd, 0, 6, 4095); v_rnd = set_el(v_rnd, 0, 7, 4095);
    v_rnd = set_el(v_rnd, 1, 6, 4095); v_rnd = set_el(v_rnd, 1, 7, 4095);

    rst = 1'b1; start = 1'b0; din = '0;
    #2;
    chk_v("reset_dout", dout, '0);
    chk_i("reset_done", int'(done), 0);
    chk_i("reset_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Ramp
    issue(v_ramp, 1'b0);
    wait_done("ramp");
    chk_i("ramp_busy_cycles", bcnt, 16);
    chk_i("ramp_00", el(0, 0), 80);
    chk_i("ramp_01", el(0, 1), 100);
    chk_i("ramp_10", el(1, 0), 240);
    chk_i("ramp_33", el(3, 3), 620);
    repeat (3) @(negedge clk);
    chk_i("done_hold", int'(done), 1);
    chk_v("dout_hold", dout, model(v_ramp));

    // Rounding
    issue(v_rnd, 1'b0);
    wait_done("round");
    chk_i("round_1112", el(0, 0), 1);
    chk_i("round_1122", el(0, 1), 2);
    chk_i("round_0003", el(0, 2), 1);
    chk_i("round_max",  el(0, 3), 4095);

    // Start pulse during CALC is ignored
    @(negedge clk);
    issue(v_ramp, 1'b0);
    repeat (4) @(negedge clk);
    din = v_b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start");
    chk_i("busy_start_busy_cycles", bcnt, 16);

    // Input changes after accept do not matter
    @(negedge clk);
    issue(v_b, 1'b0);
    din = '0;
    wait_done("input_hold");

    // Reset mid-run, then start on the first edge after release
    @(negedge clk);
    issue(v_ramp, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_v("midrst_dout", dout, '0);
    chk_i("midrst_done", int'(done), 0);
    chk_i("midrst_busy", int'(busy), 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(v_b, 1'b0);
    wait_done("after_reset");

    // Continuous start: back-to-back runs
    @(negedge clk);
    issue(v_ramp, 1'b1);
    wait_done("cont_first");
    din = v_b;
    q.push_back(model(v_b));
    @(negedge clk);
    acc_cyc = cyc;
    chk_i("cont_reaccept_done", int'(done), 0);
    chk_i("cont_reaccept_busy", int'(busy), 1);
    chk_v("cont_reaccept_dout_cleared", dout, '0);
    start = 1'b0;
    wait_done("cont_second");

    repeat (3) @(negedge clk);
    chk_i("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/top_downsample.md
TOP_DOWNSAMPLE -- requirements
Module: top_downsample

Interface
REQ-001 Parameter number_of_row, default 4, SHALL set output rows and columns; input is (2*number_of_row) x (2*number_of_row).
REQ-002 Parameter length, default 12, SHALL set the unsigned fixed-point element width in bits.
REQ-003 Parameter frac, default 8, SHALL give the fractional bits of the element format; averaging preserves the format, so frac does not change arithmetic.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 start  input  1  request to process din; level-sampled at rising edges.
REQ-007 din  input  length*4*number_of_row^2  input matrix, row-major; element (r,c) at bit slice [(r*2N+c)*length +: length], N=number_of_row.
REQ-008 dout  output  length*number_of_row^2  output matrix, row-major; element (R,C) at [(R*N+C)*length +: length]; registered.
REQ-009 busy  output  1  high while the block is capturing or computing.
REQ-010 done  output  1  high when dout holds a complete result; registered.

Function
REQ-011 FSM SHALL have states IDLE, CALC, DONE.
REQ-012 IDLE or DONE with start=1 at an edge: capture din into an internal register, clear dout to 0, clear done, set index counter to 0, go to CALC (the accept edge).
REQ-013 IDLE or DONE with start=0: hold state; dout and done unchanged.
REQ-014 CALC: each edge writes dout element idx from the captured copy, then increments idx; idx runs 0..N^2-1 in row-major order.
REQ-015 Element (R,C) SHALL be (a+b+c+d+2)>>2, where a,b,c,d are captured elements (2R,2C), (2R,2C+1), (2R+1,2C), (2R+1,2C+1); the sum is length+2 bits wide and the result is truncated to length bits (cannot overflow).
REQ-016 The edge that writes idx=N^2-1 SHALL move to DONE and set done=1, i.e. done rises N^2 edges after the accept edge (16 for N=4).
REQ-017 In DONE, done stays 1 and dout is stable until the next accept edge or reset.
REQ-018 busy=1 exactly in CALC; done and busy are never both 1.
REQ-019 start during CALC SHALL be ignored; no restart and no queuing.
REQ-020 din changes after the accept edge SHALL NOT affect the current result.
REQ-021 start held high continuously SHALL re-accept on the first edge in DONE, giving back-to-back runs with done high for one cycle between them.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, idx=0, done=0, busy=0, dout=0 and captured copy=0, regardless of clock.
REQ-023 rst asserted mid-CALC SHALL abort the run; after release the block waits in IDLE for a new start, and no partial done is ever produced.
REQ-024 start sampled on the first edge after rst falls SHALL be accepted normally.

Verification
REQ-025 Ramp: din element i (i=0..63) = 35+10*i, 1-cycle start pulse -> done after 16 edges; dout(0,0)=80, (0,1)=100, (1,0)=240, (3,3)=620; busy high for exactly 16 cycles.
REQ-026 Rounding: blocks {1,1,1,2} -> 1, {1,1,2,2} -> 2, {0,0,0,3} -> 1, all 4095 -> 4095 (no wrap).
REQ-027 Busy start: pulse start again at cycle 5 of CALC with different din -> ignored; done timing and values as in the first run.
REQ-028 Input hold: change din to all 0 one cycle after accept -> result still from the original din.
REQ-029 Reset mid-run: assert rst at cycle 8 of CALC -> dout=0, done=0, busy=0 at once; new start afterwards gives a correct result 16 edges later.
REQ-030 Continuous start: hold start=1 across two runs with different din -> done high for one cycle, dout cleared at the re-accept edge, second result correct.
